// File: rtl/tiny_cpu_alu.sv
`timescale 1ns/1ps
// tiny_cpu_alu
//   Registered ALU with accumulator for the tiny CPU. ADD/SUB/AND/OR/XOR
//   complete at the accept edge. SHL/SHR shift one bit per cycle.
//   MUL is a WIDTH-cycle shift-add multiplier.
//
// Ports
//   clk, rst              rising-edge clock, async active-high reset
//   ena                   global enable; while low every register holds
//   in_valid / in_ready   request handshake (in_ready = ena & idle)
//   op, use_acc           opcode; use_acc selects result as operand A
//   operand_a, operand_b  operands (shift amount in b[SHAMT_W-1:0])
//   out_valid             one-cycle strobe marking a new result/flags
//   result                result register, doubles as the accumulator
//   flag_c/z/n            carry-borrow-shiftout-overflow / zero / negative
module tiny_cpu_alu #(
   parameter int WIDTH   = 8,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             use_acc,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             out_valid,
   output logic [WIDTH-1:0] result,
   output logic             flag_c,
   output logic             flag_z,
   output logic             flag_n
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_SHR = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t               state_q, state_d;
   logic [2:0]           op_q, op_d;
   logic [WIDTH-1:0]     work_q, work_d;     // shift operand or multiplicand
   logic [2*WIDTH-1:0]   prod_q, prod_d;     // {partial high, multiplier/low}
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [WIDTH-1:0]     result_q, result_d;
   logic                 flag_c_q, flag_c_d;
   logic                 flag_z_q, flag_z_d;
   logic                 flag_n_q, flag_n_d;
   logic                 out_valid_q, out_valid_d;

   logic [WIDTH-1:0]     a_sel;
   logic [WIDTH:0]       add_sum;
   logic [WIDTH:0]       sub_diff;
   logic [SHAMT_W-1:0]   shamt;
   logic [WIDTH-1:0]     shift_val;
   logic                 shift_bit;
   logic [WIDTH:0]       mul_sum;
   logic                 done;
   logic [WIDTH-1:0]     done_val;
   logic                 done_c;

   assign in_ready = ena & (state_q == IDLE);

   always_comb begin
      // NOTE: every comb output gets a default before any branch so no path
      // leaves it unassigned; a missing default would infer a latch.
      state_d     = state_q;
      op_d        = op_q;
      work_d      = work_q;
      prod_d      = prod_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      flag_c_d    = flag_c_q;
      flag_z_d    = flag_z_q;
      flag_n_d    = flag_n_q;
      out_valid_d = out_valid_q;   // holds while ena is low
      done        = 1'b0;
      done_val    = '0;
      done_c      = 1'b0;

      a_sel    = use_acc ? result_q : operand_a;
      add_sum  = {1'b0, a_sel} + {1'b0, operand_b};
      // Bit WIDTH of the extended difference is the borrow (set iff A < B).
      sub_diff = {1'b0, a_sel} - {1'b0, operand_b};
      shamt    = operand_b[SHAMT_W-1:0];

      shift_val = (op_q == OP_SHL) ? {work_q[WIDTH-2:0], 1'b0} : {1'b0, work_q[WIDTH-1:1]};
      shift_bit = (op_q == OP_SHL) ? work_q[WIDTH-1] : work_q[0];
      // Shift-add step: add multiplicand into the high half when the current
      // multiplier bit (LSB of the low half) is set, then shift everything right.
      mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, work_q} : '0);

      if (ena) begin
         out_valid_d = 1'b0;
         if (state_q == IDLE) begin
            if (in_valid) begin
               op_d = op;
               case (op)
                  OP_ADD: begin done = 1'b1; done_val = add_sum[WIDTH-1:0];  done_c = add_sum[WIDTH];  end
                  OP_SUB: begin done = 1'b1; done_val = sub_diff[WIDTH-1:0]; done_c = sub_diff[WIDTH]; end
                  OP_AND: begin done = 1'b1; done_val = a_sel & operand_b; end
                  OP_OR:  begin done = 1'b1; done_val = a_sel | operand_b; end
                  OP_XOR: begin done = 1'b1; done_val = a_sel ^ operand_b; end
                  OP_SHL, OP_SHR: begin
                     work_d = a_sel;
                     cnt_d  = CNT_W'(shamt);
                     if (shamt == '0) begin
                        done     = 1'b1;
                        done_val = a_sel;
                     end else begin
                        state_d = BUSY;
                     end
                  end
                  default: begin   // OP_MUL
                     work_d  = a_sel;
                     prod_d  = {{WIDTH{1'b0}}, operand_b};
                     cnt_d   = CNT_W'(WIDTH);
                     state_d = BUSY;
                  end
               endcase
            end
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
            if (op_q == OP_MUL) begin
               prod_d   = {mul_sum, prod_q[WIDTH-1:1]};
               done_val = prod_d[WIDTH-1:0];
               done_c   = |prod_d[2*WIDTH-1:WIDTH];
            end else begin
               work_d   = shift_val;
               done_val = shift_val;
               done_c   = shift_bit;
            end
            if (cnt_q == CNT_W'(1)) begin
               done    = 1'b1;
               state_d = IDLE;
            end
         end

         if (done) begin
            result_d    = done_val;
            flag_c_d    = done_c;
            flag_z_d    = (done_val == '0);
            flag_n_d    = done_val[WIDTH-1];
            out_valid_d = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         op_q        <= OP_ADD;
         work_q      <= '0;
         prod_q      <= '0;
         cnt_q       <= '0;
         result_q    <= '0;
         flag_c_q    <= 1'b0;
         flag_z_q    <= 1'b0;
         flag_n_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         work_q      <= work_d;
         prod_q      <= prod_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         flag_c_q    <= flag_c_d;
         flag_z_q    <= flag_z_d;
         flag_n_q    <= flag_n_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flag_c    = flag_c_q;
   assign flag_z    = flag_z_q;
   assign flag_n    = flag_n_q;

endmodule

// File: tb/tb_tiny_cpu_alu.sv
`timescale 1ns/1ps
// tb_tiny_cpu_alu
//   Directed bench for tiny_cpu_alu (WIDTH=8). Requests push their expected
//   result, flags and latency into a queue; completions pop and compare.
//   Inputs are driven and outputs sampled on the falling clock edge.
module tb_tiny_cpu_alu;

   localparam int W = 8;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                          XOR_ = 3'b100, SHL = 3'b101, SHR = 3'b110, MUL = 3'b111;

   logic         clk = 1'b0;
   logic         rst, ena, in_valid, in_ready, use_acc;
   logic [2:0]   op;
   logic [W-1:0] operand_a, operand_b, result;
   logic         out_valid, flag_c, flag_z, flag_n;

   tiny_cpu_alu #(.WIDTH(W), .SHAMT_W(3)) dut (
      .clk(clk), .rst(rst), .ena(ena), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .use_acc(use_acc), .operand_a(operand_a), .operand_b(operand_b),
      .out_valid(out_valid), .result(result), .flag_c(flag_c), .flag_z(flag_z),
      .flag_n(flag_n)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] r;
      logic         c;
      logic         z;
      logic         n;
      int           issue;
      int           lat;
   } exp_t;

   exp_t         exp_q[$];
   int           n_pass  = 0;
   int           n_total = 0;
   int           cyc     = 0;
   logic [W-1:0] acc_model = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_total++;
      assert (obs === exp_v) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   // Independent reference: whole-word arithmetic, not iterative.
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t         e;
      logic [15:0]  wide;
      int           s;
      s     = int'(b[2:0]);
      e.c   = 1'b0;
      e.lat = 1;
      e.issue = 0;
      case (o)
         ADD:  begin wide = 16'(a) + 16'(b); e.r = wide[7:0]; e.c = wide[8]; end
         SUB:  begin e.r = a - b; e.c = (a < b); end
         AND_: e.r = a & b;
         OR_:  e.r = a | b;
         XOR_: e.r = a ^ b;
         SHL:  begin e.r = a << s; e.c = (s == 0) ? 1'b0 : a[W-s]; e.lat = 1 + s; end
         SHR:  begin e.r = a >> s; e.c = (s == 0) ? 1'b0 : a[s-1]; e.lat = 1 + s; end
         default: begin wide = 16'(a) * 16'(b); e.r = wide[7:0]; e.c = |wide[15:8]; e.lat = 1 + W; end
      endcase
      e.z = (e.r == '0);
      e.n = e.r[W-1];
      return e;
   endfunction

   // Drive a request in the current cycle; it is accepted at the next edge.
   task automatic send(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ua);
      exp_t e;
      check({tag, ".in_ready"}, in_ready, 1);
      op        = o;
      operand_a = a;
      operand_b = b;
      use_acc   = ua;
      in_valid  = 1'b1;
      e         = model(o, ua ? acc_model : a, b);
      e.issue   = cyc + 1;
      acc_model = e.r;
      exp_q.push_back(e);
   endtask

   task automatic idle();
      in_valid = 1'b0;
      use_acc  = 1'b0;
   endtask

   // Wait (bounded) for a completion strobe, then pop and compare.
   task automatic expect_out(input string tag);
      exp_t e;
      int   waited = 0;
      while (!out_valid && waited < 40) begin
         tick();
         waited++;
      end
      check({tag, ".out_valid"}, out_valid, 1);
      check({tag, ".sb_nonempty"}, exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check({tag, ".latency"}, cyc - e.issue + 1, e.lat);
         check({tag, ".result"}, result, e.r);
         check({tag, ".c"}, flag_c, e.c);
         check({tag, ".z"}, flag_z, e.z);
         check({tag, ".n"}, flag_n, e.n);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish (observed timeout, required $finish)");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; ena = 1'b1; in_valid = 1'b0; use_acc = 1'b0;
      op = ADD; operand_a = '0; operand_b = '0;
      tick();
      tick();
      rst = 1'b0;
      check("reset.out_valid", out_valid, 0);
      check("reset.result", result, 0);
      check("reset.flags", {flag_c, flag_z, flag_n}, 0);
      check("reset.in_ready", in_ready, 1);

      // ADD with carry, then an idle cycle drops out_valid.
      send("add", ADD, 8'd200, 8'd100, 1'b0); tick(); idle();
      expect_out("add");
      tick();
      check("add.idle_out_valid", out_valid, 0);

      // Back-to-back SUBs: zero result, then borrow.
      send("sub0", SUB, 8'd5, 8'd5, 1'b0); tick();
      send("sub1", SUB, 8'd3, 8'd5, 1'b0);
      expect_out("sub0");
      tick(); idle();
      expect_out("sub1");

      // SHL by 3: busy for three cycles.
      tick();
      send("shl", SHL, 8'h81, 8'd3, 1'b0); tick(); idle();
      for (int i = 0; i < 3; i++) begin
         check($sformatf("shl.busy_ready%0d", i), in_ready, 0);
         check($sformatf("shl.busy_valid%0d", i), out_valid, 0);
         tick();
      end
      expect_out("shl");

      // SHR by 1 accepted in the out_valid cycle.
      send("shr", SHR, 8'h81, 8'd1, 1'b0); tick(); idle();
      expect_out("shr");

      // Shift boundaries: amount 0 completes immediately, amount 7 is the max.
      send("shl0", SHL, 8'h5A, 8'd0, 1'b0); tick(); idle();
      expect_out("shl0");
      send("shl7", SHL, 8'h03, 8'd7, 1'b0); tick(); idle();
      expect_out("shl7");

      // Multiplies: no overflow, overflow to zero, full-scale.
      send("mul15x17", MUL, 8'd15, 8'd17, 1'b0); tick(); idle();
      expect_out("mul15x17");
      send("mul16x16", MUL, 8'd16, 8'd16, 1'b0); tick(); idle();
      expect_out("mul16x16");
      send("mul255", MUL, 8'd255, 8'd255, 1'b0); tick(); idle();
      expect_out("mul255");

      // Accumulator chaining, one op per cycle.
      send("chain0", ADD, 8'd10, 8'd0, 1'b0); tick();
      send("chain1", ADD, 8'd77, 8'd5, 1'b1);
      expect_out("chain0");
      tick();
      send("chain2", XOR_, 8'd99, 8'h0F, 1'b1);
      expect_out("chain1");
      tick(); idle();
      expect_out("chain2");

      // Three disabled cycles in the middle of SHR by 4 stretch latency to 8.
      tick();
      send("shr_ena", SHR, 8'h98, 8'd4, 1'b0);
      exp_q[$].lat = exp_q[$].lat + 3;
      tick(); idle();
      tick();
      ena = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("ena.ready%0d", i), in_ready, 0);
         tick();
         check($sformatf("ena.valid%0d", i), out_valid, 0);
      end
      ena = 1'b1;
      expect_out("shr_ena");

      // With ena low, a request is ignored and out_valid holds its value.
      ena = 1'b0;
      op = ADD; operand_a = 8'd1; operand_b = 8'd1; in_valid = 1'b1;
      tick();
      check("ena_off.out_valid_held", out_valid, 1);
      check("ena_off.result_held", result, 8'h09);
      in_valid = 1'b0;
      ena = 1'b1;
      tick();
      check("ena_on.out_valid", out_valid, 0);
      check("ena_on.result", result, 8'h09);

      // Reset asserted four cycles into a MUL abandons it.
      send("mul_rst", MUL, 8'd15, 8'd17, 1'b0); tick(); idle();
      tick(); tick(); tick();
      rst = 1'b1;
      #1;
      check("rst.result", result, 0);
      check("rst.flags", {flag_c, flag_z, flag_n}, 0);
      check("rst.out_valid", out_valid, 0);
      exp_q.delete();
      acc_model = '0;
      tick();
      rst = 1'b0;
      check("rst.release_ready", in_ready, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("rst.no_valid%0d", i), out_valid, 0);
      end
      check("rst.result_after", result, 0);

      // Accumulator after reset reads zero.
      send("acc_after_rst", ADD, 8'd50, 8'd7, 1'b1); tick(); idle();
      expect_out("acc_after_rst");

      tick();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/tiny_cpu_alu.md
# tiny_cpu_alu

Parametrised, multi-cycle ALU with an accumulator for the tiny CPU. It replaces the earlier enable-gated, combinational two-operand adder with a registered datapath that provides:
- eight operations, carry/zero/negative flags, and accumulator chaining;
- a valid/ready input handshake and a single-cycle result strobe;
- iterative shift and multiply engines.

It sits between the top-level pin wrapper (operand/opcode capture) and the output mux.

## Interface
Parameters:
- WIDTH, 8: datapath width in bits. Must be at least 2.
- SHAMT_W, $clog2(WIDTH): shift-amount field width taken from operand_b.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, active-high, asynchronous assert. One clock; reset is asynchronous and active-high.
- ena  in  1  global enable. While 0, every register holds and in_ready=0.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept. Combinational: ena & (state==IDLE).
- op  in  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 SHR (logical), 111 MUL (low half).
- use_acc  in  1  when 1, operand A is the current result register instead of operand_a.
- operand_a  in  WIDTH  A operand.
- operand_b  in  WIDTH  B operand. For shifts, only b[SHAMT_W-1:0] is used.
- out_valid  out  1  registered strobe: result and flags are new.
- result  out  WIDTH  result register, which is also the accumulator.
- flag_c  out  1  carry / borrow / shifted-out bit / multiply overflow.
- flag_z  out  1  result == 0.
- flag_n  out  1  result[WIDTH-1].

## Operation
- Accept: a request is accepted on a rising edge where in_valid & in_ready is true. Operands, opcode and the use_acc-selected A are captured at that edge.
- States:
  - IDLE: default state.
  - BUSY: multi-cycle ops only; returns to IDLE on the final iteration.
- Single-cycle ops (ADD, SUB, AND, OR, XOR):
  - Result and flags are written at the accept edge.
  - State stays IDLE.
- ADD: result = (A+B) mod 2^WIDTH. flag_c = carry out.
- SUB: result = (A-B) mod 2^WIDTH. flag_c = borrow (1 iff A<B).
- Logic ops: flag_c = 0.
- SHL/SHR:
  - Work register = A; counter = shamt.
  - shamt=0: complete at the accept edge with result=A, flag_c=0.
  - Otherwise go to BUSY. Each BUSY cycle shifts the work register by one bit (zero fill) and decrements the counter. The final shift writes result.
  - flag_c = last bit shifted out.
- MUL:
  - Shift-add over exactly WIDTH BUSY cycles, one multiplier bit per cycle, building a 2·WIDTH product.
  - result = low WIDTH bits.
  - flag_c = 1 iff the high WIDTH bits are nonzero.
- Flags: flag_z and flag_n always reflect the value written to result. Flags and result change only at completion edges.
- out_valid: set to 1 at every completion edge, cleared at the next enabled edge without a completion. Back-to-back single-cycle ops keep it high continuously.
- use_acc: reads the result value present at the accept edge, i.e. the previous completion. This allows one-per-cycle chaining.
- Unused opcode bits: none; all 8 codes are defined.

## Timing
- Reset: async assertion forces the following immediately:
  - state=IDLE; result, flags, counter and work registers = 0; out_valid=0.
  - An in-flight operation is abandoned with no out_valid.
- Latency from accept edge t:
  - single-cycle ops and zero-amount shifts: out_valid high in cycle t+1;
  - shifts: t+1+shamt;
  - MUL: t+1+WIDTH.
- in_ready is low for every BUSY cycle: t+1 .. t+shamt for shifts, t+1 .. t+WIDTH for MUL. It is high again in the out_valid cycle, so a new request can be accepted there.
- Throughput: single-cycle ops sustain one per cycle.
- ena=0:
  - All state freezes: counter, work registers, result, flags, and out_valid, which holds its value.
  - Latency is extended by the number of disabled cycles.
  - in_valid is ignored.
- in_valid while BUSY: ignored. The requester must hold its request until in_ready.

## Test plan
- Reset then ADD: WIDTH=8, ADD a=200, b=100 -> cycle t+1: result=44, c=1, z=0, n=0, out_valid=1. Cycle t+2 with no request: out_valid=0.
- SUB: a=5, b=5 -> result 0, z=1, c=0. Next, a=3, b=5 -> result 254, c=1, n=1. Both complete in consecutive cycles with out_valid high in both.
- SHL: a=0x81, shamt=3 -> in_ready=0 at t+1..t+3; at t+4: result=0x08, c=0, out_valid=1. SHR: a=0x81, shamt=1 -> result=0x40, c=1 at t+2.
- MUL: 15×17 -> result 255, c=0, n=1 at t+9. 16×16 -> result 0, c=1, z=1 at t+9.
- Chaining: ADD a=10, b=0, then next cycle ADD use_acc=1, b=5, then XOR use_acc=1, b=0x0F -> results 10, 15, 0 on three consecutive cycles.
- Disturbances:
  - Drop ena for 3 cycles mid-SHR (shamt=4) -> result at t+8, not t+5.
  - Assert rst at t+4 of a MUL -> result and flags 0 immediately, no out_valid. in_ready=1 on the first cycle after release with ena=1.
